// File: rtl/pkt_slot_cache.sv
// Slot-based packet cache: stores tagged packets in fixed-size slots of a shared
// dual-port RAM and replays them by slot ID, optionally freeing the slot afterwards.
module pkt_slot_cache #(
    parameter int unsigned DATA_W     = 134,
    parameter int unsigned SLOT_NUM   = 32,
    parameter int unsigned SLOT_DEPTH = 128,
    parameter int unsigned ID_W       = $clog2(SLOT_NUM),
    parameter int unsigned LEN_W      = $clog2(SLOT_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_data_wr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid_wr,
    input  logic              in_valid,
    output logic [ID_W-1:0]   out_id,
    output logic              out_id_wr,
    output logic [ID_W:0]     out_free_cnt,
    input  logic [ID_W-1:0]   in_id,
    input  logic              in_id_release,
    input  logic              in_id_wr,
    output logic              in_id_ready,
    output logic              out_data_wr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid_wr,
    output logic              out_valid,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       rd_err_cnt
);
    localparam int unsigned OffW  = $clog2(SLOT_DEPTH);
    localparam int unsigned AddrW = ID_W + OffW;
    localparam int unsigned CntW  = ID_W + 1;
    localparam logic [LEN_W-1:0] FullLen = LEN_W'(SLOT_DEPTH);

    typedef enum logic [1:0] {WrIdle, WrData, WrDrop} wr_state_e;
    typedef enum logic [0:0] {RdIdle, RdData} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic [ID_W-1:0]     wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d, alloc_id;
    logic [LEN_W-1:0]    wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, rd_len_q, rd_len_d;
    logic [LEN_W-1:0]    commit_len;
    logic                rd_rel_q, rd_rel_d;
    logic [SLOT_NUM-1:0] free_q, free_d, commit_q, commit_d;
    logic [CntW-1:0]     free_cnt_q, free_cnt_d;
    logic [ID_W-1:0]     out_id_q;
    logic                out_id_wr_q;
    logic [15:0]         drop_cnt_q, rd_err_cnt_q;

    logic is_head, any_free, mem_we, alloc_en, wr_release, commit_en, drop_evt;
    logic rd_en, rd_last, rd_release, rd_err_evt;
    logic [AddrW-1:0] mem_waddr, mem_raddr;

    logic [DATA_W-1:0] mem [SLOT_NUM*SLOT_DEPTH];
    logic [LEN_W-1:0]  len_mem [SLOT_NUM];
    logic [DATA_W-1:0] rd_data_q;
    logic              out_data_wr_q, out_valid_wr_q;

    assign is_head  = in_data_wr && (in_data[DATA_W-1 -: 2] == 2'b01);
    assign any_free = |free_q;

    // Lowest-index free slot; only slots free at the start of the cycle are eligible.
    always_comb begin
        alloc_id = '0;
        for (int i = int'(SLOT_NUM) - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_id = ID_W'(i);
        end
    end

    always_comb begin
        free_cnt_d = '0;
        for (int i = 0; i < int'(SLOT_NUM); i++) begin
            free_cnt_d = free_cnt_d + CntW'(free_q[i]);
        end
    end

    // Write side.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_slot_d  = wr_slot_q;
        wr_cnt_d   = wr_cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = {wr_slot_q, wr_cnt_q[OffW-1:0]};
        alloc_en   = 1'b0;
        wr_release = 1'b0;
        commit_en  = 1'b0;
        commit_len = wr_cnt_q;
        drop_evt   = 1'b0;
        unique case (wr_state_q)
            WrIdle: begin
                if (is_head) begin
                    if (any_free) begin
                        alloc_en   = 1'b1;
                        wr_slot_d  = alloc_id;
                        mem_we     = 1'b1;
                        mem_waddr  = {alloc_id, {OffW{1'b0}}};
                        wr_cnt_d   = LEN_W'(1);
                        wr_state_d = WrData;
                    end else begin
                        drop_evt   = 1'b1;
                        wr_state_d = WrDrop;
                    end
                end
            end
            WrData: begin
                if (in_data_wr && wr_cnt_q == FullLen) begin
                    wr_release = 1'b1;
                    drop_evt   = 1'b1;
                    wr_state_d = in_valid_wr ? WrIdle : WrDrop;
                end else begin
                    if (in_data_wr) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + LEN_W'(1);
                    end
                    if (in_valid_wr) begin
                        if (in_valid) begin
                            commit_en  = 1'b1;
                            commit_len = wr_cnt_d;
                        end else begin
                            wr_release = 1'b1;
                            drop_evt   = 1'b1;
                        end
                        wr_state_d = WrIdle;
                    end
                end
            end
            WrDrop: begin
                if (in_valid_wr) wr_state_d = WrIdle;
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Read side: one read issued per cycle in RdData; the extra cycle at
    // rd_cnt == len is where the slot is released and ready is restored.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_slot_d  = rd_slot_q;
        rd_cnt_d   = rd_cnt_q;
        rd_len_d   = rd_len_q;
        rd_rel_d   = rd_rel_q;
        rd_en      = 1'b0;
        rd_release = 1'b0;
        rd_err_evt = 1'b0;
        unique case (rd_state_q)
            RdIdle: begin
                if (in_id_wr) begin
                    if (commit_q[in_id]) begin
                        rd_state_d = RdData;
                        rd_slot_d  = in_id;
                        rd_len_d   = len_mem[in_id];
                        rd_rel_d   = in_id_release;
                        rd_cnt_d   = '0;
                    end else begin
                        rd_err_evt = 1'b1;
                    end
                end
            end
            RdData: begin
                rd_err_evt = in_id_wr;
                if (rd_cnt_q != rd_len_q) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + LEN_W'(1);
                end else begin
                    rd_release = rd_rel_q;
                    rd_state_d = RdIdle;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    assign mem_raddr = {rd_slot_q, rd_cnt_q[OffW-1:0]};
    assign rd_last   = (rd_cnt_q + LEN_W'(1)) == rd_len_q;

    always_comb begin
        free_d   = free_q;
        commit_d = commit_q;
        if (alloc_en) free_d[alloc_id] = 1'b0;
        if (wr_release) free_d[wr_slot_q] = 1'b1;
        if (commit_en) commit_d[wr_slot_q] = 1'b1;
        if (rd_release) begin
            free_d[rd_slot_q]   = 1'b1;
            commit_d[rd_slot_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= in_data;
        if (commit_en) len_mem[wr_slot_q] <= commit_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q      <= '0;
            out_data_wr_q  <= 1'b0;
            out_valid_wr_q <= 1'b0;
        end else begin
            out_data_wr_q  <= rd_en;
            out_valid_wr_q <= rd_en && rd_last;
            if (rd_en) rd_data_q <= mem[mem_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q   <= WrIdle;
            wr_slot_q    <= '0;
            wr_cnt_q     <= '0;
            rd_state_q   <= RdIdle;
            rd_slot_q    <= '0;
            rd_cnt_q     <= '0;
            rd_len_q     <= '0;
            rd_rel_q     <= 1'b0;
            free_q       <= '1;
            commit_q     <= '0;
            free_cnt_q   <= CntW'(SLOT_NUM);
            out_id_q     <= '0;
            out_id_wr_q  <= 1'b0;
            drop_cnt_q   <= '0;
            rd_err_cnt_q <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_slot_q   <= wr_slot_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_state_q  <= rd_state_d;
            rd_slot_q   <= rd_slot_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_len_q    <= rd_len_d;
            rd_rel_q    <= rd_rel_d;
            free_q      <= free_d;
            commit_q    <= commit_d;
            free_cnt_q  <= free_cnt_d;
            out_id_wr_q <= commit_en;
            if (commit_en) out_id_q <= wr_slot_q;
            if (drop_evt && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (rd_err_evt && rd_err_cnt_q != 16'hFFFF) rd_err_cnt_q <= rd_err_cnt_q + 16'd1;
        end
    end

    assign out_id       = out_id_q;
    assign out_id_wr    = out_id_wr_q;
    assign out_free_cnt = free_cnt_q;
    assign in_id_ready  = (rd_state_q == RdIdle);
    assign out_data_wr  = out_data_wr_q;
    assign out_data     = rd_data_q;
    assign out_valid_wr = out_valid_wr_q;
    assign out_valid    = out_valid_wr_q;
    assign drop_cnt     = drop_cnt_q;
    assign rd_err_cnt   = rd_err_cnt_q;

endmodule

// File: tb/tb_pkt_slot_cache.sv
// Scoreboard bench for pkt_slot_cache: expected IDs and replay words are queued
// when stimulus is driven and checked by a monitor on the falling edge.
module tb_pkt_slot_cache;
    localparam int DW = 134;
    localparam int NS = 32;
    localparam int SD = 128;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_data_wr;
    logic [DW-1:0] in_data;
    logic          in_valid_wr;
    logic          in_valid;
    logic [IW-1:0] out_id;
    logic          out_id_wr;
    logic [IW:0]   out_free_cnt;
    logic [IW-1:0] in_id;
    logic          in_id_release;
    logic          in_id_wr;
    logic          in_id_ready;
    logic          out_data_wr;
    logic [DW-1:0] out_data;
    logic          out_valid_wr;
    logic          out_valid;
    logic [15:0]   drop_cnt;
    logic [15:0]   rd_err_cnt;

    pkt_slot_cache dut (
        .clk          (clk),
        .rst          (rst),
        .in_data_wr   (in_data_wr),
        .in_data      (in_data),
        .in_valid_wr  (in_valid_wr),
        .in_valid     (in_valid),
        .out_id       (out_id),
        .out_id_wr    (out_id_wr),
        .out_free_cnt (out_free_cnt),
        .in_id        (in_id),
        .in_id_release(in_id_release),
        .in_id_wr     (in_id_wr),
        .in_id_ready  (in_id_ready),
        .out_data_wr  (out_data_wr),
        .out_data     (out_data),
        .out_valid_wr (out_valid_wr),
        .out_valid    (out_valid),
        .drop_cnt     (drop_cnt),
        .rd_err_cnt   (rd_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } exp_word_t;

    exp_word_t     exp_q[$];
    int            exp_id_q[$];
    logic [DW-1:0] model_words [NS][SD];
    int            model_len [NS];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    exp_word_t mon_e;
    int        mon_id;
    always @(negedge clk) begin
        if (out_id_wr === 1'b1) begin
            checks++;
            if (exp_id_q.size() == 0) begin
                errors++;
                $display("FAIL out_id_wr: unexpected pulse with id=%0d, want none", out_id);
            end else begin
                mon_id = exp_id_q.pop_front();
                if (out_id !== IW'(mon_id)) begin
                    errors++;
                    $display("FAIL out_id: got %0d, want %0d", out_id, mon_id);
                end
            end
        end
        if (out_data_wr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_data_wr: unexpected word %h at cyc %0d, want none", out_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data || out_valid_wr !== mon_e.last ||
                    out_valid !== mon_e.last || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL out_data: got cyc %0d data %h tail %b valid %b, want cyc %0d data %h tail %b",
                             cyc, out_data, out_valid_wr, out_valid, mon_e.cyc, mon_e.data, mon_e.last);
                end
            end
        end else if (out_valid_wr !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL out_valid_wr: got %b without out_data_wr, want 0", out_valid_wr);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk_word(input int i, input int len);
        logic [159:0] r;
        logic [1:0]   tag;
        r   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        tag = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
        return {tag, r[DW-3:0]};
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        exp_q.delete();
        exp_id_q.delete();
    endtask

    // exp_id < 0: no commit expected; otherwise the packet must come back as exp_id.
    task automatic send_pkt(input int len, input bit verdict, input int exp_id);
        logic [DW-1:0] w;
        for (int i = 0; i < len; i++) begin
            w           = mk_word(i, len);
            in_data_wr  = 1'b1;
            in_data     = w;
            in_valid_wr = (i == len - 1);
            in_valid    = verdict && (i == len - 1);
            if (exp_id >= 0 && i < SD) model_words[exp_id][i] = w;
            if (i == len - 1 && verdict && exp_id >= 0) begin
                model_len[exp_id] = len;
                exp_id_q.push_back(exp_id);
            end
            tick;
        end
        in_data_wr  = 1'b0;
        in_valid_wr = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic replay(input int id, input bit rel, input bit ok);
        int        k;
        int        n;
        exp_word_t e;
        n = 0;
        while (in_id_ready !== 1'b1 && n < 500) begin
            tick;
            n++;
        end
        checks++;
        if (in_id_ready !== 1'b1) begin
            errors++;
            $display("FAIL replay_wait_ready: got ready=%b, want 1", in_id_ready);
        end
        k             = cyc;
        in_id         = IW'(id);
        in_id_release = rel;
        in_id_wr      = 1'b1;
        if (ok) begin
            for (int i = 0; i < model_len[id]; i++) begin
                e.data = model_words[id][i];
                e.last = (i == model_len[id] - 1);
                e.cyc  = k + 2 + i;
                exp_q.push_back(e);
            end
        end
        tick;
        in_id_wr = 1'b0;
        checks++;
        if (in_id_ready !== !ok) begin
            errors++;
            $display("FAIL replay_ready_after_req id %0d: got %b, want %b", id, in_id_ready, !ok);
        end
        if (ok) begin
            n = 0;
            while (in_id_ready !== 1'b1 && n < 300) begin
                tick;
                n++;
            end
            checks++;
            if (cyc != k + 2 + model_len[id]) begin
                errors++;
                $display("FAIL replay_ready_return id %0d: got cyc %0d, want cyc %0d",
                         id, cyc, k + 2 + model_len[id]);
            end
        end
    endtask

    task automatic drain(input string what);
        int n = 0;
        while ((exp_q.size() != 0 || exp_id_q.size() != 0) && n < 400) begin
            tick;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_id_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d words %0d ids outstanding, want 0",
                     what, exp_q.size(), exp_id_q.size());
            exp_q.delete();
            exp_id_q.delete();
        end
        tick;
        tick;
    endtask

    task automatic check_free(input string what, input int want);
        checks++;
        if (out_free_cnt !== (IW + 1)'(want)) begin
            errors++;
            $display("FAIL %s free_cnt: got %0d, want %0d", what, out_free_cnt, want);
        end
    endtask

    task automatic check_drop(input string what, input int want);
        checks++;
        if (drop_cnt !== 16'(want)) begin
            errors++;
            $display("FAIL %s drop_cnt: got %0d, want %0d", what, drop_cnt, want);
        end
    endtask

    task automatic test_reset;
        logic [DW-1:0] w;
        rst = 1'b1;
        tick;
        checks++;
        if ({out_id_wr, out_data_wr, out_valid_wr, out_valid} !== 4'b0 || out_data !== '0 ||
            out_id !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got id_wr %b data_wr %b vwr %b v %b id %0d data %h, want all 0",
                     out_id_wr, out_data_wr, out_valid_wr, out_valid, out_id, out_data);
        end
        check_free("reset", 32);
        check_drop("reset", 0);
        checks++;
        if (in_id_ready !== 1'b1 || rd_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_read_side: got ready %b rd_err %0d, want 1 and 0", in_id_ready, rd_err_cnt);
        end
        rst = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            in_data_wr = 1'b1;
            in_data    = mk_word(i, 6);
            tick;
        end
        in_data_wr = 1'b0;
        rst        = 1'b1;
        tick;
        rst = 1'b0;
        // Tail of the abandoned packet must be ignored in idle.
        for (int i = 3; i < 6; i++) begin
            in_data_wr  = 1'b1;
            in_data     = mk_word(i, 6);
            in_valid_wr = (i == 5);
            in_valid    = (i == 5);
            tick;
        end
        in_data_wr  = 1'b0;
        in_valid_wr = 1'b0;
        in_valid    = 1'b0;
        tick;
        tick;
        check_free("reset_mid_packet", 32);
        check_drop("reset_mid_packet", 0);
        send_pkt(4, 1'b1, 0);
        drain("reset_next_pkt");
    endtask

    task automatic test_commit_replay;
        check_free("commit", 31);
        replay(0, 1'b1, 1'b1);
        drain("commit_replay");
        check_free("replay_release", 32);
    endtask

    task automatic test_discard;
        do_reset;
        send_pkt(2, 1'b0, -1);
        drain("discard");
        check_drop("discard", 1);
        check_free("discard", 32);
        send_pkt(3, 1'b1, 0);
        drain("discard_reuse");
        replay(0, 1'b1, 1'b1);
        drain("discard_reuse_replay");
    endtask

    task automatic test_fill_and_drop;
        do_reset;
        for (int i = 0; i < NS; i++) send_pkt(2 + (i % 3), 1'b1, i);
        drain("fill");
        check_free("fill", 0);
        send_pkt(3, 1'b1, -1);
        drain("no_slot");
        check_drop("no_slot", 1);
        replay(5, 1'b1, 1'b1);
        drain("fill_replay5");
        check_free("fill_release5", 1);
        send_pkt(2, 1'b1, 5);
        drain("fill_reuse5");
        check_free("fill_reuse5", 0);
    endtask

    task automatic test_oversize;
        do_reset;
        send_pkt(129, 1'b1, -1);
        drain("oversize");
        check_drop("oversize", 1);
        check_free("oversize", 32);
        send_pkt(SD, 1'b1, 0);
        drain("max_len");
        replay(0, 1'b1, 1'b1);
        drain("max_len_replay");
        check_drop("max_len", 1);
    endtask

    task automatic test_retain_and_errors;
        int        k;
        exp_word_t e;
        do_reset;
        send_pkt(3, 1'b1, 0);
        send_pkt(2, 1'b1, 1);
        send_pkt(4, 1'b1, 2);
        send_pkt(5, 1'b1, 3);
        drain("retain_setup");
        replay(3, 1'b0, 1'b1);
        drain("retain_first");
        replay(3, 1'b0, 1'b1);
        drain("retain_second");
        check_free("retain", 28);
        replay(7, 1'b1, 1'b0);
        tick;
        checks++;
        if (rd_err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL uncommitted_req rd_err_cnt: got %0d, want 1", rd_err_cnt);
        end
        // A second request while the first stream is busy is rejected.
        k             = cyc;
        in_id         = 5'd3;
        in_id_release = 1'b0;
        in_id_wr      = 1'b1;
        for (int i = 0; i < model_len[3]; i++) begin
            e.data = model_words[3][i];
            e.last = (i == model_len[3] - 1);
            e.cyc  = k + 2 + i;
            exp_q.push_back(e);
        end
        tick;
        in_id = 5'd0;
        tick;
        in_id_wr = 1'b0;
        checks++;
        if (rd_err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL busy_req rd_err_cnt: got %0d, want 2", rd_err_cnt);
        end
        drain("busy_req");
        check_free("busy_req", 28);
    endtask

    task automatic test_back_to_back;
        // Write to a new slot while slot 2 streams out.
        fork
            replay(2, 1'b0, 1'b1);
            send_pkt(5, 1'b1, 4);
        join
        drain("overlap");
        // Head arrives on the same edge slot 2 is released: allocation must skip it.
        fork
            replay(2, 1'b1, 1'b1);
            begin
                repeat (5) tick;
                send_pkt(2, 1'b1, 5);
            end
        join
        drain("release_alloc_same_cycle");
        send_pkt(3, 1'b1, 2);
        drain("reuse2");
        check_free("back_to_back", 26);
        replay(4, 1'b1, 1'b1);
        drain("overlap_pkt_replay");
        check_free("back_to_back_end", 27);
    endtask

    initial begin
        rst           = 1'b1;
        in_data_wr    = 1'b0;
        in_data       = '0;
        in_valid_wr   = 1'b0;
        in_valid      = 1'b0;
        in_id         = '0;
        in_id_release = 1'b0;
        in_id_wr      = 1'b0;
        test_reset;
        test_commit_replay;
        test_discard;
        test_fill_and_drop;
        test_oversize;
        test_retain_and_errors;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
